// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if
//   Bundles the hazard/control inputs and the register-enable/flush outputs of
//   the pipeline sequencing controller.
//   master : the pipeline side. It drives the hazard and halt/resume inputs and
//            receives the enables, flushes, status flags and counters.
//   slave  : the controller itself.
//   Signals:
//     load_use, branch_taken, mdu_start, halt_req, go        hazard/control
//     pc_en, if_id_en, id_ex_en, ex_mem_en                    write enables
//     if_id_flush, id_ex_flush, ex_mem_flush                  bubble inserts
//     halted, mdu_busy                                        status
//     cycle_cnt, stall_cnt, flush_cnt                         statistics
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             load_use;
  logic             branch_taken;
  logic             mdu_start;
  logic             halt_req;
  logic             go;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             halted;
  logic             mdu_busy;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output load_use, branch_taken, mdu_start, halt_req, go,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en,
    input  if_id_flush, id_ex_flush, ex_mem_flush,
    input  halted, mdu_busy, cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  load_use, branch_taken, mdu_start, halt_req, go,
    output pc_en, if_id_en, id_ex_en, ex_mem_en,
    output if_id_flush, id_ex_flush, ex_mem_flush,
    output halted, mdu_busy, cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Pipeline sequencing controller for the 5-stage MIPS core. Merges load-use,
//   taken-branch, multi-cycle mult/div occupancy and syscall halt/resume into
//   one coherent set of stall enables and flushes for the PC, IF/ID, ID/EX and
//   EX/MEM registers, and keeps cycle/stall/flush statistics.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  pipeline_stall_ctrl_if.slave (hazards in, enables/flushes/status out)
//   Parameters:
//     MDU_LAT  cycles a mult/div occupies EX (1..16; 1 = single cycle)
//     CNT_W    statistics counter width
module pipeline_stall_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_BUSY = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  // The mdu_start cycle is the first stall cycle, so MDU_BUSY covers the
  // remaining MDU_LAT-2 stall cycles before the release cycle.
  localparam logic [3:0] MDU_RELOAD = (MDU_LAT > 1) ? 4'(MDU_LAT - 2) : 4'd0;
  localparam logic       MDU_MULTI  = (MDU_LAT > 1);

  state_t     state_q, state_d;
  logic [3:0] mdu_cnt_q, mdu_cnt_d;
  logic       halt_pend_q, halt_pend_d;

  logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush;

  always_comb begin
    // Normal output set and hold-state defaults.
    state_d      = state_q;
    mdu_cnt_d    = mdu_cnt_q;
    halt_pend_d  = halt_pend_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (bus.halt_req) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
          state_d = ST_HALT;
        end else if (bus.mdu_start && MDU_MULTI) begin
          // Hold the front end; EX/MEM takes bubbles while the MDU works.
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          mdu_cnt_d    = MDU_RELOAD;
          state_d      = ST_MDU_BUSY;
        end else if (bus.branch_taken) begin
          // Squash the two wrong-path instructions; a coincident load_use
          // belongs to one of them and is therefore moot.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (bus.load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end

      ST_MDU_BUSY: begin
        if (bus.halt_req) begin
          halt_pend_d = 1'b1;
        end
        if (mdu_cnt_q != 4'd0) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          mdu_cnt_d    = mdu_cnt_q - 4'd1;
        end else begin
          // Release cycle. A halt_req arriving right now is honoured too.
          state_d     = (halt_pend_q || bus.halt_req) ? ST_HALT : ST_RUN;
          halt_pend_d = 1'b0;
        end
      end

      ST_HALT: begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
        if (bus.go) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      mdu_cnt_q   <= 4'd0;
      halt_pend_q <= 1'b0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mdu_cnt_q   <= mdu_cnt_d;
      halt_pend_q <= halt_pend_d;
      if (state_q != ST_HALT) begin
        cycle_cnt_q <= cycle_cnt_q + 1'b1;
        if (!pc_en) begin
          stall_cnt_q <= stall_cnt_q + 1'b1;
        end
      end
      if (if_id_flush) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.halted       = (state_q == ST_HALT);
  assign bus.mdu_busy     = (state_q == ST_MDU_BUSY);
  assign bus.cycle_cnt    = cycle_cnt_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl
//   Directed bench for pipeline_stall_ctrl with MDU_LAT = 4. Inputs change on
//   the falling edge; combinational outputs are sampled 1 ns later, registered
//   counters 1 ns after the rising edge.
module tb_pipeline_stall_ctrl;

  localparam int CNT_W = 32;

  // Output vector: {pc_en, if_id_en, id_ex_en, ex_mem_en,
  //                 if_id_flush, id_ex_flush, ex_mem_flush, halted, mdu_busy}
  localparam logic [8:0] O_NORMAL   = 9'b1111_000_00;
  localparam logic [8:0] O_FROZEN   = 9'b0000_000_00;
  localparam logic [8:0] O_HALTED   = 9'b0000_000_10;
  localparam logic [8:0] O_LOADUSE  = 9'b0011_010_00;
  localparam logic [8:0] O_BRANCH   = 9'b1111_110_00;
  localparam logic [8:0] O_MDU_ST   = 9'b0001_001_00;
  localparam logic [8:0] O_MDU_BUSY = 9'b0001_001_01;
  localparam logic [8:0] O_MDU_REL  = 9'b1111_000_01;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(.MDU_LAT(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
            bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush,
            bus.halted, bus.mdu_busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, check outputs before the
  // next rising edge.
  task automatic step(input logic rs, input logic lu, input logic br, input logic ms,
                      input logic hr, input logic g, input logic [8:0] exp, input string tag);
    @(negedge clk);
    rst              = rs;
    bus.load_use     = lu;
    bus.branch_taken = br;
    bus.mdu_start    = ms;
    bus.halt_req     = hr;
    bus.go           = g;
    #1;
    check(tag, 32'(outs()), 32'(exp));
    $display("step %-12s rst=%0b lu=%0b br=%0b ms=%0b hr=%0b go=%0b outs=%09b",
             tag, rs, lu, br, ms, hr, g, outs());
  endtask

  // Counters after the rising edge that closes the previous step.
  task automatic check_cnt(input string tag, input int cyc, input int stl, input int fl);
    @(posedge clk);
    #1;
    check({tag, ".cycle"}, bus.cycle_cnt, 32'(cyc));
    check({tag, ".stall"}, bus.stall_cnt, 32'(stl));
    check({tag, ".flush"}, bus.flush_cnt, 32'(fl));
    $display("cnt  %-12s cycle=%0d stall=%0d flush=%0d", tag,
             bus.cycle_cnt, bus.stall_cnt, bus.flush_cnt);
  endtask

  initial begin
    rst              = 1'b1;
    bus.load_use     = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mdu_start    = 1'b0;
    bus.halt_req     = 1'b0;
    bus.go           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.outs", 32'(outs()), 32'(O_NORMAL));
    check("rst.cycle", bus.cycle_cnt, 32'd0);
    check("rst.stall", bus.stall_cnt, 32'd0);
    check("rst.flush", bus.flush_cnt, 32'd0);

    // Ten idle cycles.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, O_NORMAL, "idle");
    check_cnt("idle", 10, 0, 0);

    // Load-use: one stall cycle.
    step(0, 1, 0, 0, 0, 0, O_LOADUSE, "loaduse");
    step(0, 0, 0, 0, 0, 0, O_NORMAL, "lu_after");
    check_cnt("loaduse", 12, 1, 0);

    // Branch overrides coincident load-use.
    step(0, 1, 1, 0, 0, 0, O_BRANCH, "br_lu");
    check_cnt("br_lu", 13, 1, 1);

    // MDU, mdu_start held four cycles.
    step(0, 0, 0, 1, 0, 0, O_MDU_ST, "mdu1");
    step(0, 0, 0, 1, 0, 0, O_MDU_BUSY, "mdu2");
    step(0, 0, 0, 1, 0, 0, O_MDU_BUSY, "mdu3");
    step(0, 0, 0, 1, 0, 0, O_MDU_REL, "mdu4_rel");
    step(0, 0, 0, 0, 0, 0, O_NORMAL, "mdu5_run");
    check_cnt("mdu", 18, 4, 1);

    // MDU with halt_req on the second stall cycle.
    step(0, 0, 0, 1, 0, 0, O_MDU_ST, "mh1");
    step(0, 0, 0, 1, 1, 0, O_MDU_BUSY, "mh2_halt");
    step(0, 0, 0, 1, 0, 0, O_MDU_BUSY, "mh3");
    step(0, 0, 0, 1, 0, 0, O_MDU_REL, "mh4_rel");
    step(0, 0, 0, 0, 0, 0, O_HALTED, "mh5_halt");
    step(0, 1, 1, 1, 1, 0, O_HALTED, "mh6_ign");
    step(0, 0, 0, 0, 0, 0, O_HALTED, "mh7");
    step(0, 0, 0, 0, 0, 1, O_HALTED, "mh_go");
    check_cnt("mh_halted", 22, 7, 1);
    step(0, 0, 0, 0, 0, 0, O_NORMAL, "mh_resume");
    check_cnt("mh_resume", 23, 7, 1);

    // go ignored in RUN; halt from RUN.
    step(0, 0, 0, 0, 0, 1, O_NORMAL, "go_ign");
    step(0, 0, 0, 0, 1, 0, O_FROZEN, "halt_run");
    step(0, 0, 0, 0, 0, 0, O_HALTED, "halted");
    step(0, 0, 0, 0, 0, 1, O_HALTED, "go2");
    step(0, 0, 0, 0, 0, 0, O_NORMAL, "resume2");
    check_cnt("halt_run", 26, 8, 1);

    // Plain branch.
    step(0, 0, 1, 0, 0, 0, O_BRANCH, "branch");
    check_cnt("branch", 27, 8, 2);

    // Reset during MDU_BUSY with a pending halt.
    step(0, 0, 0, 1, 0, 0, O_MDU_ST, "rm1");
    step(0, 0, 0, 1, 1, 0, O_MDU_BUSY, "rm2_halt");
    step(1, 0, 0, 0, 0, 0, O_MDU_BUSY, "rm3_rst");
    check_cnt("rm_rst", 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, O_NORMAL, "rm_after");
    check_cnt("rm_after", 4, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
